// File: rtl/pipe_pkg.sv
// Shared pipeline-stage layout: widths, EX/ME field offsets and the stage-register state encoding.
// Purely declarative; no latency or flow control of its own.
package pipe_pkg;

    localparam int XLEN      = 32;
    localparam int MEM_LEN_W = 2;

    // Control payload bit positions (side-effect bits that must die on a bubble)
    localparam int CTRL_REG_W  = 0;
    localparam int CTRL_MEM_W  = 1;
    localparam int CTRL_MEM_R  = 2;
    localparam int CTRL_BRANCH = 3;
    localparam int STAGE_CTRL_W = 4;

    // Data payload field offsets; the top 3 bits are spare so every stage shares one 198-bit layout
    localparam int DATA_VAL_LSB       = 0;
    localparam int DATA_REG_DATA_LSB  = DATA_VAL_LSB + XLEN;
    localparam int DATA_MEM_ADDR_LSB  = DATA_REG_DATA_LSB + XLEN;
    localparam int DATA_MEM_DATA_LSB  = DATA_MEM_ADDR_LSB + XLEN;
    localparam int DATA_BRANCH_PC_LSB = DATA_MEM_DATA_LSB + XLEN;
    localparam int DATA_PC_LSB        = DATA_BRANCH_PC_LSB + XLEN;
    localparam int DATA_MEM_LEN_LSB   = DATA_PC_LSB + XLEN;
    localparam int DATA_MEM_UNS_BIT   = DATA_MEM_LEN_LSB + MEM_LEN_W;
    localparam int STAGE_DATA_W       = 198;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic logic [1:0] occ_of(input state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ST_ONE:  occ = 2'd1;
            ST_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stream carrying one pipeline entry (ctrl + data); master drives valid/ctrl/data.
// No storage: latency 0, ready flows from slave back to master.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = STAGE_CTRL_W,
    parameter int DATA_W = STAGE_DATA_W
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One held pipeline entry; load captures ctrl/data, clear kills valid/ctrl but keeps data to avoid toggling.
// Latency 1 cycle; no flow control of its own, clear has priority over load.
module pipe_slot #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 198
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              vld,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            ctrl <= '0;
            data <= '0;
        end else if (clear) begin
            vld  <= 1'b0;
            ctrl <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            ctrl <= ctrl_d;
            data <= data_d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with flush and bubble gating; optional skid entry gives a registered in_ready.
// Latency 1 cycle; SKID=1 absorbs one entry under backpressure at full rate, SKID=0 passes out_ready through.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = STAGE_DATA_W,
    parameter int CTRL_W = STAGE_CTRL_W,
    parameter bit SKID   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    pipe_stage_skid_if.slave          in_if,
    pipe_stage_skid_if.master         out_if,
    output logic [1:0]                occupancy
);

    state_t            state_q, state_d;
    logic              in_rdy;
    logic              in_xfer, out_xfer;
    logic              main_load, main_clear, skid_load, skid_clear, use_skid;
    logic              main_vld;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_d, skid_ctrl;
    logic [DATA_W-1:0] main_data, main_data_d, skid_data;

    assign in_xfer  = in_if.valid & in_rdy;
    assign out_xfer = main_vld & out_if.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        use_skid   = 1'b0;
        if (flush) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end else if (out_xfer) begin
                        state_d    = ST_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain of main can happen
                    if (out_xfer) begin
                        state_d    = ST_ONE;
                        main_load  = 1'b1;
                        use_skid   = 1'b1;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    assign main_ctrl_d = use_skid ? skid_ctrl : in_if.ctrl;
    assign main_data_d = use_skid ? skid_data : in_if.data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (main_load),
        .clear  (main_clear),
        .ctrl_d (main_ctrl_d),
        .data_d (main_data_d),
        .vld    (main_vld),
        .ctrl   (main_ctrl),
        .data   (main_data)
    );

    generate
        if (SKID) begin : g_skid
            logic skid_vld;

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (skid_load),
                .clear  (skid_clear),
                .ctrl_d (in_if.ctrl),
                .data_d (in_if.data),
                .vld    (skid_vld),
                .ctrl   (skid_ctrl),
                .data   (skid_data)
            );

            // Skid occupied <=> state TWO, so its valid flop doubles as the registered ready
            assign in_rdy = ~skid_vld;
        end else begin : g_noskid
            assign skid_ctrl = '0;
            assign skid_data = '0;
            assign in_rdy    = ~main_vld | out_if.ready;
        end
    endgenerate

    assign in_if.ready  = in_rdy;
    assign out_if.valid = main_vld;
    assign out_if.ctrl  = main_ctrl & {CTRL_W{main_vld}};
    assign out_if.data  = main_data;
    assign occupancy    = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: SKID=1 and SKID=0 instances, directed table, corner sequences, random vs FIFO model.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = STAGE_DATA_W;
    localparam int CW = STAGE_CTRL_W;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       flush1 = 1'b0;
    logic       flush0 = 1'b0;
    logic [1:0] occ1, occ0;

    pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) s1_in ();
    pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) s1_out ();
    pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) s0_in ();
    pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) s0_out ();

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush1),
        .in_if     (s1_in),
        .out_if    (s1_out),
        .occupancy (occ1)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush0),
        .in_if     (s0_in),
        .out_if    (s0_out),
        .occupancy (occ0)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          iv;
        logic [3:0]    ic;
        logic [7:0]    id;
        logic          ordy;
        logic          fl;
        logic          ev;
        logic [3:0]    ec;
        logic [7:0]    ed;
        logic [1:0]    eo;
        logic          er;
    } vec_t;

    vec_t tbl[13];

    // FIFO reference model per instance: [1]=SKID=1 (capacity 2), [0]=SKID=0 (capacity 1)
    logic [CW-1:0] m_ctrl[2][2];
    logic [DW-1:0] m_data[2][2];
    int            m_cnt[2];
    logic [DW-1:0] m_last[2];

    logic          r_v[2], r_r[2], r_f[2];
    logic [CW-1:0] r_c[2];
    logic [DW-1:0] r_d[2];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_st(input int d, input string tag, input logic ev, input logic [CW-1:0] ec,
                          input logic [DW-1:0] ed, input logic [1:0] eo, input logic er);
        if (d == 1) begin
            chk({tag, "/s1.out_valid"}, DW'(s1_out.valid), DW'(ev));
            chk({tag, "/s1.out_ctrl"},  DW'(s1_out.ctrl),  DW'(ec));
            chk({tag, "/s1.out_data"},  s1_out.data,       ed);
            chk({tag, "/s1.occupancy"}, DW'(occ1),         DW'(eo));
            chk({tag, "/s1.in_ready"},  DW'(s1_in.ready),  DW'(er));
        end else begin
            chk({tag, "/s0.out_valid"}, DW'(s0_out.valid), DW'(ev));
            chk({tag, "/s0.out_ctrl"},  DW'(s0_out.ctrl),  DW'(ec));
            chk({tag, "/s0.out_data"},  s0_out.data,       ed);
            chk({tag, "/s0.occupancy"}, DW'(occ0),         DW'(eo));
            chk({tag, "/s0.in_ready"},  DW'(s0_in.ready),  DW'(er));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv1(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic r, input logic f);
        s1_in.valid  = v;
        s1_in.ctrl   = c;
        s1_in.data   = d;
        s1_out.ready = r;
        flush1       = f;
    endtask

    task automatic drv0(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic r, input logic f);
        s0_in.valid  = v;
        s0_in.ctrl   = c;
        s0_in.data   = d;
        s0_out.ready = r;
        flush0       = f;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [223:0] t;
        for (int k = 0; k < 7; k++) t[k*32 +: 32] = $urandom();
        return t[DW-1:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach summary in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed vectors for SKID=1: columns are inputs then expected state after the edge
        tbl[0]  = '{1'b1, 4'h1, 8'h0A, 1'b0, 1'b0,  1'b1, 4'h1, 8'h0A, 2'd1, 1'b1};
        tbl[1]  = '{1'b1, 4'h2, 8'h0B, 1'b0, 1'b0,  1'b1, 4'h1, 8'h0A, 2'd2, 1'b0};
        tbl[2]  = '{1'b1, 4'h3, 8'h0C, 1'b0, 1'b0,  1'b1, 4'h1, 8'h0A, 2'd2, 1'b0};
        tbl[3]  = '{1'b1, 4'h3, 8'h0C, 1'b1, 1'b0,  1'b1, 4'h2, 8'h0B, 2'd1, 1'b1};
        tbl[4]  = '{1'b1, 4'h3, 8'h0C, 1'b1, 1'b0,  1'b1, 4'h3, 8'h0C, 2'd1, 1'b1};
        tbl[5]  = '{1'b0, 4'hF, 8'h0D, 1'b1, 1'b0,  1'b0, 4'h0, 8'h0C, 2'd0, 1'b1};
        tbl[6]  = '{1'b0, 4'hF, 8'h0D, 1'b0, 1'b0,  1'b0, 4'h0, 8'h0C, 2'd0, 1'b1};
        tbl[7]  = '{1'b1, 4'h5, 8'h11, 1'b0, 1'b0,  1'b1, 4'h5, 8'h11, 2'd1, 1'b1};
        tbl[8]  = '{1'b1, 4'h6, 8'h12, 1'b0, 1'b0,  1'b1, 4'h5, 8'h11, 2'd2, 1'b0};
        tbl[9]  = '{1'b1, 4'h7, 8'h13, 1'b0, 1'b1,  1'b0, 4'h0, 8'h11, 2'd0, 1'b1};
        tbl[10] = '{1'b1, 4'h8, 8'h14, 1'b1, 1'b1,  1'b0, 4'h0, 8'h11, 2'd0, 1'b1};
        tbl[11] = '{1'b1, 4'h9, 8'h15, 1'b1, 1'b0,  1'b1, 4'h9, 8'h15, 2'd1, 1'b1};
        tbl[12] = '{1'b0, 4'h0, 8'h00, 1'b1, 1'b0,  1'b0, 4'h0, 8'h15, 2'd0, 1'b1};

        drv1(1'b0, 4'h0, '0, 1'b1, 1'b0);
        drv0(1'b0, 4'h0, '0, 1'b1, 1'b0);
        #2;
        chk_st(1, "reset", 1'b0, 4'h0, '0, 2'd0, 1'b1);
        chk_st(0, "reset", 1'b0, 4'h0, '0, 2'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming 1..8 with no backpressure: one entry out per cycle, no gaps
        for (int k = 1; k <= 8; k++) begin
            drv1(1'b1, 4'h1, DW'(k), 1'b1, 1'b0);
            tick();
            chk_st(1, $sformatf("stream%0d", k), 1'b1, 4'h1, DW'(k), 2'd1, 1'b1);
        end
        drv1(1'b0, 4'h1, DW'(9), 1'b1, 1'b0);
        tick();
        chk_st(1, "stream_drain", 1'b0, 4'h0, DW'(8), 2'd0, 1'b1);

        for (int i = 0; i < 13; i++) begin
            drv1(tbl[i].iv, tbl[i].ic, DW'(tbl[i].id), tbl[i].ordy, tbl[i].fl);
            tick();
            chk_st(1, $sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ec, DW'(tbl[i].ed), tbl[i].eo, tbl[i].er);
        end
        drv1(1'b0, 4'h0, '0, 1'b1, 1'b0);

        // SKID=0: ready follows out_ready combinationally while full
        drv0(1'b1, 4'h1, DW'(8'h21), 1'b0, 1'b0);
        tick();
        chk_st(0, "s0_fill", 1'b1, 4'h1, DW'(8'h21), 2'd1, 1'b0);
        drv0(1'b1, 4'h2, DW'(8'h22), 1'b0, 1'b0);
        tick();
        chk_st(0, "s0_stall", 1'b1, 4'h1, DW'(8'h21), 2'd1, 1'b0);
        s0_out.ready = 1'b1;
        #1;
        chk("s0_comb_ready", DW'(s0_in.ready), DW'(1'b1));
        for (int k = 0; k < 4; k++) begin
            drv0(1'b1, 4'h2, DW'(32'h22 + k), 1'b1, 1'b0);
            tick();
            chk_st(0, $sformatf("s0_stream%0d", k), 1'b1, 4'h2, DW'(32'h22 + k), 2'd1, 1'b1);
        end
        drv0(1'b0, 4'h0, '0, 1'b1, 1'b0);
        tick();
        chk_st(0, "s0_drain", 1'b0, 4'h0, DW'(8'h25), 2'd0, 1'b1);

        // Async reset while the SKID=1 stage is full
        drv1(1'b1, 4'h1, DW'(8'h31), 1'b0, 1'b0);
        tick();
        drv1(1'b1, 4'h2, DW'(8'h32), 1'b0, 1'b0);
        tick();
        chk_st(1, "pre_reset_full", 1'b1, 4'h1, DW'(8'h31), 2'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_st(1, "mid_reset", 1'b0, 4'h0, '0, 2'd0, 1'b1);
        drv1(1'b1, 4'h3, DW'(8'h77), 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_st(1, "post_reset_accept", 1'b1, 4'h3, DW'(8'h77), 2'd1, 1'b1);
        drv1(1'b0, 4'h0, '0, 1'b1, 1'b0);
        tick();

        // Random traffic on both instances against the FIFO model
        #2;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_last[d] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                r_v[d] = ($urandom_range(0, 9) < 7);
                r_r[d] = ($urandom_range(0, 9) < 6);
                r_f[d] = ($urandom_range(0, 19) == 0);
                r_c[d] = CW'($urandom());
                r_d[d] = rand_data();
            end
            drv1(r_v[1], r_c[1], r_d[1], r_r[1], r_f[1]);
            drv0(r_v[0], r_c[0], r_d[0], r_r[0], r_f[0]);
            #1;
            for (int d = 0; d < 2; d++) begin
                logic          e_rdy, e_v, ox, ix;
                logic [CW-1:0] e_c;
                logic [DW-1:0] e_d;
                e_rdy = (d == 1) ? (m_cnt[d] < 2) : (m_cnt[d] == 0 || r_r[d]);
                e_v   = (m_cnt[d] > 0);
                e_c   = e_v ? m_ctrl[d][0] : '0;
                e_d   = e_v ? m_data[d][0] : m_last[d];
                chk_st(d, $sformatf("rand%0d", cyc), e_v, e_c, e_d, 2'(m_cnt[d]), e_rdy);
                if (r_f[d]) begin
                    m_cnt[d] = 0;
                end else begin
                    ox = e_v && r_r[d];
                    ix = r_v[d] && e_rdy;
                    if (ox) begin
                        m_ctrl[d][0] = m_ctrl[d][1];
                        m_data[d][0] = m_data[d][1];
                        m_cnt[d]--;
                    end
                    if (ix) begin
                        m_ctrl[d][m_cnt[d]] = r_c[d];
                        m_data[d][m_cnt[d]] = r_d[d];
                        m_cnt[d]++;
                    end
                end
                if (m_cnt[d] > 0) m_last[d] = m_data[d][0];
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
